// File: rtl/video_sync_gen.sv
// Raster timing generator for 1280x1024@60Hz.
// Produces registered sync, active, coordinates and line/frame strobes, all for the same pixel.
module video_sync_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter bit H_POL     = 1'b1,
  parameter bit V_POL     = 1'b1,
  parameter int CW        = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pll_locked,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic          running_reg, running_next;
  logic [CW-1:0] hcount_reg, hcount_next;
  logic [CW-1:0] vcount_reg, vcount_next;
  logic          hsync_reg, vsync_reg, active_reg;
  logic          line_start_reg, frame_start_reg;
  logic          hsync_win, vsync_win;

  // Next raster position; reset and lock loss both collapse to idle at (0,0).
  always_comb begin
    running_next = running_reg;
    hcount_next  = hcount_reg;
    vcount_next  = vcount_reg;
    if (reset || !pll_locked) begin
      running_next = 1'b0;
      hcount_next  = '0;
      vcount_next  = '0;
    end else if (!running_reg) begin
      running_next = 1'b1;
      hcount_next  = '0;
      vcount_next  = '0;
    end else if (hcount_reg == H_LAST) begin
      hcount_next = '0;
      vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
    end else begin
      hcount_next = hcount_reg + 1'b1;
    end
  end

  // Decode from the next position so every registered output matches the registered counts.
  always_comb begin
    hsync_win = (int'(hcount_next) >= H_VISIBLE + H_FP) &&
                (int'(hcount_next) <  H_VISIBLE + H_FP + H_SYNC);
    vsync_win = (int'(vcount_next) >= V_VISIBLE + V_FP) &&
                (int'(vcount_next) <  V_VISIBLE + V_FP + V_SYNC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running_reg     <= 1'b0;
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      running_reg     <= running_next;
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hsync_reg       <= (running_next && hsync_win) ? H_POL : ~H_POL;
      vsync_reg       <= (running_next && vsync_win) ? V_POL : ~V_POL;
      active_reg      <= running_next && (int'(hcount_next) < H_VISIBLE) &&
                         (int'(vcount_next) < V_VISIBLE);
      line_start_reg  <= running_next && (hcount_next == '0);
      frame_start_reg <= running_next && (hcount_next == '0) && (vcount_next == '0);
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign active      = active_reg;
  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: full-size instance for line timing, a scaled active-low
// instance (25x16 raster) for frame-level, lock-loss and reset corner cases.
module tb_video_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size 1280x1024 instance, active-high syncs.
  logic        reset_a, locked_a;
  logic        hsync_a, vsync_a, active_a, line_start_a, frame_start_a;
  logic [10:0] hcount_a, vcount_a;

  video_sync_gen dut_a (
    .clk(clk), .reset(reset_a), .pll_locked(locked_a),
    .hsync(hsync_a), .vsync(vsync_a), .active(active_a),
    .hcount(hcount_a), .vcount(vcount_a),
    .line_start(line_start_a), .frame_start(frame_start_a)
  );

  // Scaled instance: H 16+2+3+4=25, V 10+1+2+3=16, frame = 400 cycles, active-low syncs.
  logic       reset_b, locked_b;
  logic       hsync_b, vsync_b, active_b, line_start_b, frame_start_b;
  logic [5:0] hcount_b, vcount_b;

  video_sync_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_VISIBLE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b0), .CW(6)
  ) dut_b (
    .clk(clk), .reset(reset_b), .pll_locked(locked_b),
    .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
    .hcount(hcount_b), .vcount(vcount_b),
    .line_start(line_start_b), .frame_start(frame_start_b)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic rst;
    logic lock;
    int   h;
    int   v;
    logic act;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end else begin
      $display("[TB] ok %s = %0d", name, actual);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pack_a();
    return int'({hcount_a, vcount_a, active_a, hsync_a, vsync_a, line_start_a, frame_start_a});
  endfunction

  function automatic int pack_b();
    return int'({hcount_b, vcount_b, active_b, hsync_b, vsync_b, line_start_b, frame_start_b});
  endfunction

  function automatic int exp_a(int h, int v, logic act, logic hs, logic vs, logic ls, logic fs);
    return int'({11'(h), 11'(v), act, hs, vs, ls, fs});
  endfunction

  function automatic int exp_b(int h, int v, logic act, logic hs, logic vs, logic ls, logic fs);
    return int'({6'(h), 6'(v), act, hs, vs, ls, fs});
  endfunction

  initial begin
    int   hs_cnt, hs_first, last_h, vs_cnt, vs_first_h, vs_first_v, fs_t, hsl_cnt, hsl_first;
    bit   found;

    reset_a = 1'b1; locked_a = 1'b1;
    reset_b = 1'b1; locked_b = 1'b1;

    //               rst   lock  h  v  act   hs    vs    ls    fs
    tbl[0]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < 15; i++) begin
      reset_a  = tbl[i].rst;
      locked_a = tbl[i].lock;
      step();
      chk($sformatf("vec%0d", i), pack_a(),
          exp_a(tbl[i].h, tbl[i].v, tbl[i].act, tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs));
    end

    // Active edge at the end of the visible line.
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      step();
      if (hcount_a == 11'd1279) found = 1'b1;
    end
    chk("a_reach_1279", int'(found), 1);
    chk("a_active_at_1279", int'(active_a), 1);
    step();
    chk("a_h_1280", int'(hcount_a), 1280);
    chk("a_active_at_1280", int'(active_a), 0);

    // hsync window and line wrap.
    hs_cnt = 0; hs_first = -1; last_h = int'(hcount_a); found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      step();
      if (hcount_a == 11'd0) found = 1'b1;
      else begin
        last_h = int'(hcount_a);
        if (hsync_a) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(hcount_a);
        end
      end
    end
    chk("a_wrap_seen", int'(found), 1);
    chk("a_last_h_before_wrap", last_h, 1687);
    chk("a_hsync_cycles", hs_cnt, 112);
    chk("a_hsync_first_h", hs_first, 1328);
    chk("a_wrap_state", pack_a(), exp_a(0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));

    // Reset while hsync is asserted.
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      step();
      if (hcount_a == 11'd1400) found = 1'b1;
    end
    chk("a_at_1400", pack_a(), exp_a(1400, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    reset_a = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("a_reset_idle%0d", n), pack_a(), exp_a(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    // Scaled instance: idle sync level is high for active-low polarity.
    step();
    chk("b_idle", pack_b(), exp_b(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    reset_b = 1'b0;
    step();
    chk("b_start", pack_b(), exp_b(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));

    // One full frame: vsync window, hsync window, frame period.
    vs_cnt = 0; vs_first_h = -1; vs_first_v = -1; fs_t = -1; hsl_cnt = 0; hsl_first = -1;
    for (int t = 1; t <= 420; t++) begin
      step();
      if (t < 400 && vsync_b == 1'b0) begin
        vs_cnt++;
        if (vs_first_h < 0) begin
          vs_first_h = int'(hcount_b);
          vs_first_v = int'(vcount_b);
        end
      end
      if (t < 25 && hsync_b == 1'b0) begin
        hsl_cnt++;
        if (hsl_first < 0) hsl_first = int'(hcount_b);
      end
      if (frame_start_b && fs_t < 0) fs_t = t;
    end
    chk("b_vsync_cycles", vs_cnt, 50);
    chk("b_vsync_first_h", vs_first_h, 0);
    chk("b_vsync_first_v", vs_first_v, 11);
    chk("b_hsync_cycles", hsl_cnt, 3);
    chk("b_hsync_first_h", hsl_first, 18);
    chk("b_frame_period", fs_t, 400);

    // Reset with both syncs active.
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      step();
      if (hcount_b == 6'd19 && vcount_b == 6'd11) found = 1'b1;
    end
    chk("b_at_19_11", pack_b(), exp_b(19, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset_b = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("b_reset_idle%0d", n), pack_b(), exp_b(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    reset_b = 1'b0;
    step();
    chk("b_restart", pack_b(), exp_b(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));

    // Lock loss mid-frame, regained after 10 cycles.
    found = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      step();
      if (hcount_b == 6'd7 && vcount_b == 6'd5) found = 1'b1;
    end
    chk("b_at_7_5", pack_b(), exp_b(7, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    locked_b = 1'b0;
    step();
    chk("b_unlock_idle", pack_b(), exp_b(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int n = 0; n < 9; n++) step();
    chk("b_unlock_hold", pack_b(), exp_b(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    locked_b = 1'b1;
    step();
    chk("b_relock_start", pack_b(), exp_b(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    step();
    chk("b_relock_next", pack_b(), exp_b(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
